// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: PC-indexed branch history table of saturating counters.
// Decode looks up a prediction combinationally and carries the returned index
// down the pipe. Execute writes the resolved outcome back through that index.
// Resolved-branch and mispredict statistics are kept for performance counting.
//
// Optional feature: define BHT_GSHARE_EN to XOR a non-speculative global
// history register into the low bits of the lookup index (gshare).
//
// Ports:
//   Clock, nReset        - clock, synchronous active-low reset
//   lookupValid/PC       - decode-stage branch lookup request
//   predictTaken/Index   - combinational prediction and table index used
//   updateValid/Index    - execute-stage resolution, index carried from decode
//   updateTaken          - resolved outcome
//   updatePredicted      - prediction originally used for this branch
//   mispredict           - registered pulse, last update disagreed with prediction
//   branchCount          - saturating count of resolved branches
//   mispredictCount      - saturating count of mispredictions
module branch_predictor_bht #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned GHR_WIDTH = 6
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       lookupValid,
  input  logic [31:0]                lookupPC,
  output logic                       predictTaken,
  output logic [$clog2(ENTRIES)-1:0] predictIndex,
  input  logic                       updateValid,
  input  logic [$clog2(ENTRIES)-1:0] updateIndex,
  input  logic                       updateTaken,
  input  logic                       updatePredicted,
  output logic                       mispredict,
  output logic [31:0]                branchCount,
  output logic [31:0]                mispredictCount
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [31:0]          CNT_MAX  = 32'hFFFF_FFFF;

  logic [CTR_WIDTH-1:0] table_q [ENTRIES];
  logic [CTR_WIDTH-1:0] ctr_cur;
  logic [CTR_WIDTH-1:0] ctr_d;
  logic [IDX_W-1:0]     pc_idx;
  logic [IDX_W-1:0]     lookup_idx;
  logic                 mispredict_q, mispredict_d;
  logic [31:0]          branch_count_q, branch_count_d;
  logic [31:0]          mispredict_count_q, mispredict_count_d;

  // PC bits outside the index field and the history width only matter in
  // some configurations; fold them into one deliberately unused net.
  logic unused_cfg;
  assign unused_cfg = ^{lookupPC[31:IDX_W+2], lookupPC[1:0], (GHR_WIDTH > IDX_W)};

  assign pc_idx = lookupPC[IDX_W+1:2];

`ifdef BHT_GSHARE_EN
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;

  // Same-cycle lookup sees the pre-shift history.
  assign lookup_idx = pc_idx ^ IDX_W'(ghr_q);

  // History shifts in the resolved outcome at the LSB, oldest bit falls off.
  always_comb begin
    ghr_d = ghr_q;
    if (updateValid) begin
      ghr_d = GHR_WIDTH'({ghr_q, updateTaken});
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign lookup_idx = pc_idx;
`endif

  // Lookup reads the registered table: read-old on a same-cycle update.
  assign predictIndex = lookup_idx;
  assign predictTaken = lookupValid & table_q[lookup_idx][CTR_WIDTH-1];

  // Saturating counter step for the entry being resolved.
  always_comb begin
    ctr_cur = table_q[updateIndex];
    ctr_d   = ctr_cur;
    if (updateTaken) begin
      if (ctr_cur != CTR_MAX) ctr_d = ctr_cur + CTR_WIDTH'(1);
    end else begin
      if (ctr_cur != '0) ctr_d = ctr_cur - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (updateValid) begin
      table_q[updateIndex] <= ctr_d;
    end
  end

  // Statistics: both counters stick at all-ones rather than wrapping.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    mispredict_d       = updateValid & (updateTaken ^ updatePredicted);
    if (updateValid) begin
      if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + 32'd1;
      if (mispredict_d && (mispredict_count_q != CNT_MAX)) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign mispredict      = mispredict_q;
  assign branchCount     = branch_count_q;
  assign mispredictCount = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed self-checking bench for branch_predictor_bht at default parameters.
module tb_branch_predictor_bht;

  localparam int unsigned IDX_W = 6;

  logic             clk;
  logic             n_reset;
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             predict_taken;
  logic [IDX_W-1:0] predict_index;
  logic             update_valid;
  logic [IDX_W-1:0] update_index;
  logic             update_taken;
  logic             update_predicted;
  logic             mispredict;
  logic [31:0]      branch_count;
  logic [31:0]      mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_bht #(.ENTRIES(64), .CTR_WIDTH(2), .GHR_WIDTH(6)) dut (
    .Clock           (clk),
    .nReset          (n_reset),
    .lookupValid     (lookup_valid),
    .lookupPC        (lookup_pc),
    .predictTaken    (predict_taken),
    .predictIndex    (predict_index),
    .updateValid     (update_valid),
    .updateIndex     (update_index),
    .updateTaken     (update_taken),
    .updatePredicted (update_predicted),
    .mispredict      (mispredict),
    .branchCount     (branch_count),
    .mispredictCount (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge; inputs change and outputs are sampled at negedge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
    update_valid     = 1'b1;
    update_index     = idx;
    update_taken     = taken;
    update_predicted = pred;
    tick();
    update_valid     = 1'b0;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0; pcs[1] = 32'h14; pcs[2] = 32'hFC;
    apply_reset();
    lookup_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lookup_pc = pcs[i];
      #1;
      n_checks++;
      if (predict_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_predict pc=%h got %b exp 0", pcs[i], predict_taken);
      end
    end
    n_checks++;
    if (branch_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_branchCount got %h exp 0", branch_count);
    end
    n_checks++;
    if (mispredict_count !== 32'd0) begin
      n_fail++; $display("FAIL reset_mispredictCount got %h exp 0", mispredict_count);
    end
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL reset_mispredict got %b exp 0", mispredict);
    end
  endtask

  task automatic test_saturation();
    // Counter at index 5 starts at 1: T,T,T,N,N,N,N,T -> 2,3,3,2,1,0,0,1
    logic       dirs [8];
    logic       exps [8];
    dirs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exps = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    for (int i = 0; i < 8; i++) begin
      do_update(6'd5, dirs[i], dirs[i]);
      n_checks++;
      if (predict_taken !== exps[i]) begin
        n_fail++;
        $display("FAIL saturation step %0d got %b exp %b", i, predict_taken, exps[i]);
      end
    end
    // Counter back to 0 for the next scenario.
    do_update(6'd5, 1'b0, 1'b0);
    lookup_pc = 32'h18;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL saturation_neighbour got %b exp 0", predict_taken);
    end
  endtask

  task automatic test_aliasing();
    do_update(6'd5, 1'b1, 1'b0);
    do_update(6'd5, 1'b1, 1'b0);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h114;
    #1;
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL alias_predict got %b exp 1", predict_taken);
    end
    n_checks++;
    if (predict_index !== 6'd5) begin
      n_fail++; $display("FAIL alias_index got %0d exp 5", predict_index);
    end
    lookup_pc = 32'h18;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL alias_other_predict got %b exp 0", predict_taken);
    end
    n_checks++;
    if (predict_index !== 6'd6) begin
      n_fail++; $display("FAIL alias_other_index got %0d exp 6", predict_index);
    end
    lookup_valid = 1'b0;
    lookup_pc    = 32'h14;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL lookup_invalid got %b exp 0", predict_taken);
    end
  endtask

  task automatic test_hazard();
    // Counter[5] is 2; one not-taken brings it to 1.
    do_update(6'd5, 1'b0, 1'b1);
    lookup_valid     = 1'b1;
    lookup_pc        = 32'h14;
    update_valid     = 1'b1;
    update_index     = 6'd5;
    update_taken     = 1'b1;
    update_predicted = 1'b0;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL hazard_same_cycle got %b exp 0", predict_taken);
    end
    tick();
    update_valid = 1'b0;
    #1;
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL hazard_next_cycle got %b exp 1", predict_taken);
    end
  endtask

  task automatic test_stats();
    logic mis [10];
    int   pulses;
    mis = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pulses = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      update_valid     = 1'b1;
      update_index     = 6'd7;
      update_taken     = i[0];
      update_predicted = i[0] ^ mis[i];
      if (i == 0) begin
        #1;
        n_checks++;
        if (branch_count !== 32'd0) begin
          n_fail++; $display("FAIL stats_before_edge got %0d exp 0", branch_count);
        end
      end
      tick();
      n_checks++;
      if (mispredict !== mis[i]) begin
        n_fail++; $display("FAIL stats_pulse update %0d got %b exp %b", i, mispredict, mis[i]);
      end
      if (mispredict === 1'b1) pulses++;
    end
    update_valid = 1'b0;
    tick();
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL stats_idle_pulse got %b exp 0", mispredict);
    end
    n_checks++;
    if (pulses != 3) begin
      n_fail++; $display("FAIL stats_pulse_count got %0d exp 3", pulses);
    end
    n_checks++;
    if (branch_count !== 32'd10) begin
      n_fail++; $display("FAIL stats_branchCount got %0d exp 10", branch_count);
    end
    n_checks++;
    if (mispredict_count !== 32'd3) begin
      n_fail++; $display("FAIL stats_mispredictCount got %0d exp 3", mispredict_count);
    end
    // Preload branch counter to all ones, then one mispredicting update.
    force dut.branch_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count_q;
    do_update(6'd7, 1'b1, 1'b0);
    n_checks++;
    if (branch_count !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL stats_saturate got %h exp ffffffff", branch_count);
    end
    n_checks++;
    if (mispredict_count !== 32'd4) begin
      n_fail++; $display("FAIL stats_mis_after_sat got %0d exp 4", mispredict_count);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    do_update(6'd5, 1'b1, 1'b1);
    do_update(6'd5, 1'b1, 1'b1);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    #1;
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL midreset_pretrain got %b exp 1", predict_taken);
    end
    // Reset and a mispredicting taken update on the same edge.
    n_reset          = 1'b0;
    update_valid     = 1'b1;
    update_index     = 6'd5;
    update_taken     = 1'b1;
    update_predicted = 1'b0;
    tick();
    n_reset      = 1'b1;
    update_valid = 1'b0;
    #1;
    n_checks++;
    if (predict_taken !== 1'b0) begin
      n_fail++; $display("FAIL midreset_predict got %b exp 0", predict_taken);
    end
    n_checks++;
    if (branch_count !== 32'd0) begin
      n_fail++; $display("FAIL midreset_branchCount got %0d exp 0", branch_count);
    end
    n_checks++;
    if (mispredict !== 1'b0) begin
      n_fail++; $display("FAIL midreset_mispredict got %b exp 0", mispredict);
    end
    // Counter must be exactly 1: a single taken flips it to predict taken.
    do_update(6'd5, 1'b1, 1'b0);
    n_checks++;
    if (predict_taken !== 1'b1) begin
      n_fail++; $display("FAIL midreset_counter_one got %b exp 1", predict_taken);
    end
  endtask

`ifdef BHT_GSHARE_EN
  task automatic test_gshare();
    apply_reset();
    do_update(6'd0, 1'b1, 1'b1);
    do_update(6'd0, 1'b1, 1'b1);
    do_update(6'd0, 1'b0, 1'b0);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h14;
    #1;
    n_checks++;
    if (predict_index !== 6'd3) begin
      n_fail++; $display("FAIL gshare_index got %0d exp 3", predict_index);
    end
  endtask
`endif

  initial begin
    n_reset          = 1'b1;
    lookup_valid     = 1'b0;
    lookup_pc        = '0;
    update_valid     = 1'b0;
    update_index     = '0;
    update_taken     = 1'b0;
    update_predicted = 1'b0;
    @(negedge clk);
    test_reset();
    test_saturation();
    test_aliasing();
    test_hazard();
    test_stats();
    test_mid_reset();
`ifdef BHT_GSHARE_EN
    test_gshare();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised branch history table that replaces the single-bit global prediction register with a PC-indexed array of saturating counters. Decode looks up a prediction for the fetched PC in the same cycle and carries the returned index down the pipe. Execute writes the resolved outcome back through that index. The block also keeps branch and mispredict statistics for performance counting.

## Interface
Parameters:
- `ENTRIES`, 64: table depth; power of two, ≥ 4; `IDX_W = $clog2(ENTRIES)`.
- `CTR_WIDTH`, 2: counter width in bits, 1..4.
- `GHR_WIDTH`, 6: global history length, ≤ `IDX_W`; used only with `GSHARE_EN`.

Ports:
- `Clock`  in  1  — single clock; all state on the rising edge.
- `nReset`  in  1  — synchronous, active-low reset.
- `lookupValid`  in  1  — decode holds a conditional branch.
- `lookupPC`  in  32  — PC of that branch.
- `predictTaken`  out  1  — prediction for `lookupPC`.
- `predictIndex`  out  IDX_W  — table index used; pipelined to execute with the branch.
- `updateValid`  in  1  — execute resolves a conditional branch this cycle.
- `updateIndex`  in  IDX_W  — `predictIndex` carried from decode.
- `updateTaken`  in  1  — actual outcome (branch confirmed).
- `updatePredicted`  in  1  — prediction originally used.
- `mispredict`  out  1  — registered; pulses when the last update disagreed with its prediction.
- `branchCount`  out  32  — resolved conditional branches since reset.
- `mispredictCount`  out  32  — mispredictions since reset.

## Operation
- Index: `idx = lookupPC[IDX_W+1:2]`. With `GSHARE_EN`, the low `GHR_WIDTH` bits of `idx` are XORed with the GHR.
- `predictIndex = idx` always. `predictTaken = lookupValid & table[idx][CTR_WIDTH-1]`, so a counter MSB of 1 means taken.
- Update, when `updateValid`:
  - `updateTaken = 1`: increment `table[updateIndex]`, saturating at `2^CTR_WIDTH-1`.
  - `updateTaken = 0`: decrement, saturating at 0.
  - Only the addressed entry changes.
- Statistics, when `updateValid`:
  - `branchCount` increments by 1.
  - `mispredictCount` increments if `updateTaken != updatePredicted`.
  - Both saturate at `32'hFFFF_FFFF` and never wrap.
- `mispredict` is registered `updateValid & (updateTaken ^ updatePredicted)`. It is 0 in any cycle following a cycle without `updateValid`.
- `lookupValid = 0` has no state effect.
- Aliasing is permitted: PCs that share index bits share a counter. No tags are stored.

## Timing
- Lookup is combinational from `lookupPC` and current table state: zero-cycle latency, usable in decode.
- An update written at edge N is visible to lookups from cycle N+1.
- Same-cycle lookup and update to the same index: `predictTaken` returns the pre-update value (read-old, no bypass).
- `branchCount`, `mispredictCount` and `mispredict` change on the edge after the `updateValid` cycle.
- Reset: any edge with `nReset = 0` sets the following, overriding a concurrent `updateValid`:
  - every counter to `2^(CTR_WIDTH-1)-1` (weakly not-taken; 1 for 2-bit);
  - GHR to 0, `mispredict` to 0, both statistics counters to 0.
- During reset `predictTaken` reflects the table contents. It is 0 from the first cycle after reset.
- Reset asserted mid-stream drops any in-flight update; the pipeline flushes externally.

## Configuration
- `BHT_GSHARE_EN` defined:
  - A `GHR_WIDTH`-bit global history register shifts in `updateTaken` at the LSB on each `updateValid` edge. This is non-speculative, so a mispredict needs no repair.
  - The lookup index is XORed with the GHR.
  - Same-cycle lookup uses the pre-shift GHR.
- `BHT_GSHARE_EN` undefined: no GHR flops; the index is pure PC bits.

## Test plan
Defaults throughout: `ENTRIES=64`, `CTR_WIDTH=2`.
- Reset: hold `nReset=0` for 1 edge, then look up PC `0x0`, `0x14` and `0xFC` → `predictTaken=0`, `branchCount=0`, `mispredictCount=0`, `mispredict=0`.
- Saturation at index 5 (PC `0x14`), predictions read after each update edge:
  - 3× update taken → counter 1→2→3→3, predictions 1,1,1;
  - then 3× not-taken → 2,1,0, predictions 1,0,0;
  - a 4th not-taken stays at 0.
- Aliasing: train PC `0x14` taken twice, then look up PC `0x114` → `predictTaken=1`, `predictIndex=5`. Look up PC `0x18` → 0.
- Same-cycle hazard: counter[5]=1; in one cycle look up `0x14` and update index 5 taken → `predictTaken=0` that cycle, 1 the next.
- Statistics: 10 consecutive updates, 3 with `updateTaken != updatePredicted` → `branchCount=10`, `mispredictCount=3`, and exactly 3 single-cycle `mispredict` pulses, each 1 cycle after its update. Preload `branchCount` to `FFFF_FFFF` via a force, apply one update → value holds.
- Mid-operation reset: `nReset=0` on the same edge as `updateValid=1`, taken, index 5 → counter[5]=1, `branchCount=0`.
- `BHT_GSHARE_EN` only: updates taken, taken, not-taken give GHR `0b000110`; look up `0x14` → `predictIndex=3`.
